hex_display_pio: RTL and testbench
==================================

// Module: hex_display_pio
// PURPOSE
//   Parametrised Avalon-MM slave driving 1..4 seven-segment digits (8 bits each: seg[6:0]+dp).
//   Successor to the plain HEX output PIO: byte-enabled writes, atomic bit SET/CLR,
//   per-digit hardware blink with programmable period. Sits on the system interconnect;
//   out_port goes straight to board HEX pins (active-low segments).
// PARAMETERS
//   DIGITS        4           number of digits, legal 1..4; out_port width = 8*DIGITS
//   CNT_W         26          width of blink prescaler counter and PERIOD register
//   PERIOD_RST    25000000    reset value of PERIOD (half-period in clk cycles; 0.5 s @50 MHz)
//   BLANK_PAT     8'hFF       byte driven for a digit in its blink-off phase (all segments off)
// PORTS
//   clk         in   1         system clock
//   reset_n     in   1         asynchronous, active-low reset
//   address     in   3         word address, register map below
//   chipselect  in   1         slave select
//   write_n     in   1         active-low write strobe (valid with chipselect)
//   byteenable  in   4         byte lanes for writes; ignored on reads
//   writedata   in   32        write data
//   readdata    out  32        read data, combinational (0 wait states, 0 read latency)
//   out_port    out  8*DIGITS  segment outputs, byte n = digit n
// BEHAVIOUR
//   Register map (unused bits read 0, writes to unused bits/addresses ignored):
//     0 DATA   R/W  digit bytes; byte n written only when byteenable[n] and n<DIGITS
//     1 SET    W    DATA <= DATA | (writedata & lane_mask); reads return 0
//     2 CLR    W    DATA <= DATA & ~(writedata & lane_mask); reads return 0
//     3 BLINK  R/W  bits[DIGITS-1:0]: 1 = digit blinks; lane 0 only
//     4 PERIOD R/W  bits[CNT_W-1:0]: blink half-period; all lanes honoured
//     5 STATUS R    bit0 = phase (1 = visible), bits[CNT_W+7:8] not used; read-only
//   Write accepted when chipselect && !write_n; takes effect at that clk edge.
//   Reset: DATA=0, BLINK=0, PERIOD=PERIOD_RST, counter=PERIOD_RST, phase=1; out_port = 0.
//   Blink timer: down-counter cnt. Each cycle with PERIOD!=0: if cnt==0 -> phase toggles,
//     cnt<=PERIOD-1... defined exactly: cnt==0 -> cnt<=PERIOD, phase<=~phase; else cnt<=cnt-1.
//     Phase therefore toggles every PERIOD+1 cycles.
//   PERIOD==0: timer frozen, phase forced to 1 (all digits visible).
//   Write to PERIOD: cnt reloads with new value on same edge; phase unchanged.
//   Write to BLINK: no effect on timer; takes effect on out_port next cycle.
//   out_port byte n = (BLINK[n] && !phase) ? BLANK_PAT : disp_n, registered (1-cycle from DATA).
//   Reads of DATA/BLINK/PERIOD return register value before any same-cycle write.
//   Counter arithmetic is CNT_W bits unsigned; no wrap beyond reload (reload at 0).
//   Reset asserted mid-operation: all state returns to reset values asynchronously.
// CONFIGURATION
//   HEX_DECODE_EN defined: DATA byte n = {dp[7], blank[4], hex[3:0]}; disp_n =
//     blank ? 8'hFF : {~dp, seg7(hex)} with active-low 0-F font. Readback returns raw DATA.
//   HEX_DECODE_EN undefined: disp_n = DATA byte n, raw segment pattern passthrough.
// STRUCTURE
//   Package hex_display_pkg: register address localparams (ADDR_DATA..ADDR_STATUS),
//     active-low 16-entry seven-segment font constant, BLANK default.
//   Sub-module hex_seg_decoder (4-bit hex + blank + dp -> 8-bit pattern), instantiated
//     per digit only under HEX_DECODE_EN.
// TESTING
//   Reset release: out_port=0, read PERIOD=PERIOD_RST, STATUS=1, BLINK=0.
//   Write DATA=32'h11223344 be=4'b0101 over DATA=0 -> DATA reads 32'h00220044, out_port same.
//   DATA=32'h000000F0; SET 32'h0000000F -> 32'h000000FF; CLR 32'h00000081 -> 32'h0000007E.
//   PERIOD=3, BLINK=4'b0010: byte1 alternates BLANK_PAT/data every 4 cycles; others steady.
//   PERIOD=0 while phase=0 -> STATUS=1 next cycle, all digits visible, timer frozen.
//   HEX_DECODE_EN: DATA byte0=8'h00 -> 8'hC0; 8'h8A -> 8'h08 (A with dp on); 8'h10 -> 8'hFF.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared constants for the HEX display PIO: register map, seven-segment font, blank pattern.
package hex_display_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_BLINK  = 3'd3;
    localparam logic [2:0] ADDR_PERIOD = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    localparam logic [7:0] BLANK_DEFAULT = 8'hFF;

    // Active-low segments, bit 0 = segment a ... bit 6 = segment g.
    localparam logic [6:0] SEG_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_display_pio_if.sv
// Avalon-MM slave bus bundle for the HEX display PIO (0 wait states, combinational readdata).
interface hex_display_pio_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, byteenable, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, byteenable, writedata,
        output readdata
    );

endinterface

// File: rtl/hex_seg_decoder.sv
// One digit of hex-to-seven-segment decode: {dp, blank, hex} -> active-low {dp, seg[6:0]}.
module hex_seg_decoder
    import hex_display_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] pattern
);

    assign pattern = blank ? 8'hFF : {~dp, SEG_FONT[hex]};

endmodule

// File: rtl/hex_display_pio.sv
// Avalon-MM HEX display PIO with byte-enabled writes, atomic SET/CLR and per-digit blink.
// Optional build macro HEX_DECODE_EN: DATA bytes hold {dp, blank, hex} and are font-decoded.
module hex_display_pio
    import hex_display_pkg::*;
#(
    parameter int         DIGITS     = 4,
    parameter int         CNT_W      = 26,
    parameter int         PERIOD_RST = 25000000,
    parameter logic [7:0] BLANK_PAT  = BLANK_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    hex_display_pio_if.slave      bus,
    output logic [8*DIGITS-1:0]   out_port
);

    localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(PERIOD_RST);

    logic [8*DIGITS-1:0] data_q;
    logic [DIGITS-1:0]   blink_q;
    logic [CNT_W-1:0]    period_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                phase_q;

    logic                wr_en;
    logic [8*DIGITS-1:0] lane_mask;
    logic [8*DIGITS-1:0] wr_bits;
    logic [CNT_W-1:0]    period_wr;
    logic                period_wr_en;
    logic                phase_vis;
    logic [8*DIGITS-1:0] disp;
    logic [8*DIGITS-1:0] out_next;

    assign wr_en        = bus.chipselect && !bus.write_n;
    assign period_wr_en = wr_en && (bus.address == ADDR_PERIOD);
    // A zero period freezes the timer and shows every digit, whatever phase_q holds.
    assign phase_vis    = phase_q || (period_q == '0);

    for (genvar n = 0; n < DIGITS; n++) begin : g_lane
        assign lane_mask[8*n +: 8] = {8{bus.byteenable[n]}};
    end
    assign wr_bits = bus.writedata[8*DIGITS-1:0] & lane_mask;

    for (genvar i = 0; i < CNT_W; i++) begin : g_period_bit
        assign period_wr[i] = bus.byteenable[i/8] ? bus.writedata[i] : period_q[i];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else if (wr_en) begin
            case (bus.address)
                ADDR_DATA: data_q <= (data_q & ~lane_mask) | wr_bits;
                ADDR_SET:  data_q <= data_q | wr_bits;
                ADDR_CLR:  data_q <= data_q & ~wr_bits;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_q <= '0;
        end else if (wr_en && (bus.address == ADDR_BLINK) && bus.byteenable[0]) begin
            blink_q <= bus.writedata[DIGITS-1:0];
        end
    end

    // Blink timer: a PERIOD write reloads the counter and leaves the phase alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q <= PERIOD_INIT;
            cnt_q    <= PERIOD_INIT;
            phase_q  <= 1'b1;
        end else if (period_wr_en) begin
            period_q <= period_wr;
            cnt_q    <= period_wr;
        end else if (period_q == '0) begin
            phase_q  <= 1'b1;
        end else if (cnt_q == '0) begin
            cnt_q    <= period_q;
            phase_q  <= ~phase_q;
        end else begin
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end

`ifdef HEX_DECODE_EN
    for (genvar n = 0; n < DIGITS; n++) begin : g_dec
        hex_seg_decoder u_dec (
            .hex     (data_q[8*n +: 4]),
            .blank   (data_q[8*n + 4]),
            .dp      (data_q[8*n + 7]),
            .pattern (disp[8*n +: 8])
        );
    end
`else
    assign disp = data_q;
`endif

    for (genvar n = 0; n < DIGITS; n++) begin : g_out
        assign out_next[8*n +: 8] = (blink_q[n] && !phase_vis) ? BLANK_PAT : disp[8*n +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) out_port <= '0;
        else          out_port <= out_next;
    end

    // NOTE: readdata gets a default before the case so no path can infer a latch.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:   bus.readdata = 32'(data_q);
            ADDR_BLINK:  bus.readdata = 32'(blink_q);
            ADDR_PERIOD: bus.readdata = 32'(period_q);
            ADDR_STATUS: bus.readdata = {31'b0, phase_vis};
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_hex_display_pio.sv
// Self-checking bench for hex_display_pio: directed bus traffic, a register-level model
// compared every cycle, and literal expectations for the documented scenarios.
module tb_hex_display_pio;

    localparam int          PERIOD_RST = 25000000;
    localparam logic [31:0] PERIOD_MSK = 32'h03FF_FFFF;
`ifdef HEX_DECODE_EN
    localparam logic [7:0]  BYTE1_VIS  = 8'hA4;
`else
    localparam logic [7:0]  BYTE1_VIS  = 8'h22;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] out_port;
    logic        chk_on = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    hex_display_pio_if bus ();

    hex_display_pio dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [31:0] m_data;
    logic [3:0]  m_blink;
    logic [31:0] m_period;
    int unsigned m_age;
    bit          m_phase;
    logic [31:0] m_out;

    function automatic logic [6:0] font(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [7:0] disp_byte(input logic [31:0] d, input int n);
        logic [7:0] b;
        b = d[8*n +: 8];
`ifdef HEX_DECODE_EN
        if (b[4]) return 8'hFF;
        return {~b[7], font(b[3:0])};
`else
        return b;
`endif
    endfunction

    function automatic bit visible();
        return m_phase || (m_period == 0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_data;
            3'd3:    return {28'b0, m_blink};
            3'd4:    return m_period;
            3'd5:    return {31'b0, visible()};
            default: return 32'b0;
        endcase
    endfunction

    // Phase changes once every PERIOD+1 cycles, counted from reset or the last PERIOD write.
    always @(posedge clk or negedge reset_n) begin
        logic [31:0] mask, wbits, p;
        if (!reset_n) begin
            m_data = 0; m_blink = 0; m_period = PERIOD_RST; m_age = 0; m_phase = 1; m_out = 0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                mask[8*n +: 8]  = {8{bus.byteenable[n]}};
                m_out[8*n +: 8] = (m_blink[n] && !visible()) ? 8'hFF : disp_byte(m_data, n);
            end
            wbits = bus.writedata & mask;
            if (bus.chipselect && !bus.write_n && bus.address == 3'd4) begin
                p = (m_period & ~mask) | wbits;
                m_period = p & PERIOD_MSK;
                m_age = 0;
            end else if (m_period == 0) begin
                m_phase = 1;
            end else begin
                m_age++;
                if (m_age == m_period + 1) begin
                    m_phase = !m_phase;
                    m_age = 0;
                end
            end
            if (bus.chipselect && !bus.write_n) begin
                case (bus.address)
                    3'd0: m_data = (m_data & ~mask) | wbits;
                    3'd1: m_data = m_data | wbits;
                    3'd2: m_data = m_data & ~wbits;
                    3'd3: if (bus.byteenable[0]) m_blink = bus.writedata[3:0];
                    default: ;
                endcase
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_out_port", out_port, m_out);
            check("model_readdata", bus.readdata, exp_read(bus.address));
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(posedge clk);
        #1;
        bus.address = a; bus.writedata = d; bus.byteenable = be;
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        bus.address = 3'd5; bus.byteenable = 4'h0;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        @(posedge clk);
        #1;
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        @(negedge clk);
        check(name, bus.readdata, exp);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit   found;
        bit   prev;
        logic s_blank [16];
        logic [7:0] s_b0 [16];
        int   blanks, alts, steady;

        bus.address = 3'd5; bus.chipselect = 1'b0; bus.write_n = 1'b1;
        bus.byteenable = 4'h0; bus.writedata = 32'h0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1 chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        @(negedge clk);
        check("rst_out_port", out_port, 32'h0);
        check("rst_status", bus.readdata, 32'h1);
        read_check("rst_period", 3'd4, 32'd25000000);
        read_check("rst_blink", 3'd3, 32'h0);
        read_check("rst_data", 3'd0, 32'h0);

        bus_write(3'd0, 32'h11223344, 4'b0101);
        read_check("data_be0101", 3'd0, 32'h00220044);
`ifndef HEX_DECODE_EN
        check("out_be0101", out_port, 32'h00220044);
`endif

        bus_write(3'd0, 32'h000000F0, 4'hF);
        bus_write(3'd1, 32'h0000000F, 4'hF);
        read_check("set_result", 3'd0, 32'h000000FF);
        bus_write(3'd2, 32'h00000081, 4'hF);
        read_check("clr_result", 3'd0, 32'h0000007E);

`ifdef HEX_DECODE_EN
        bus_write(3'd0, 32'h00000000, 4'h1);
        wait_neg(1);
        check("dec_zero", {24'h0, out_port[7:0]}, 32'hC0);
        bus_write(3'd0, 32'h0000008A, 4'h1);
        wait_neg(1);
        check("dec_a_dp", {24'h0, out_port[7:0]}, 32'h08);
        bus_write(3'd0, 32'h00000010, 4'h1);
        wait_neg(1);
        check("dec_blank", {24'h0, out_port[7:0]}, 32'hFF);
`endif

        // Blink digit 1 with a 4-cycle half-period.
        bus_write(3'd0, 32'h44332211, 4'hF);
        bus_write(3'd4, 32'd3, 4'hF);
        bus_write(3'd3, 32'h2, 4'h1);
        wait_neg(2);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s_blank[i] = (out_port[15:8] == 8'hFF);
            s_b0[i]    = out_port[7:0];
        end
        blanks = 0; alts = 0; steady = 0;
        for (int i = 0; i < 16; i++) begin
            if (s_blank[i]) blanks++;
            if (s_b0[i] == s_b0[0]) steady++;
        end
        for (int i = 0; i < 12; i++) if (s_blank[i] != s_blank[i+4]) alts++;
        check("blink_blank_count", blanks, 8);
        check("blink_half_period", alts, 12);
        check("blink_byte0_steady", steady, 16);

        // Freeze the timer during the off phase.
        found = 1'b0;
        prev = m_phase;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (prev && !m_phase) begin
                found = 1'b1;
                break;
            end
            prev = m_phase;
        end
        check("phase0_found", {31'b0, found}, 32'h1);
        bus_write(3'd4, 32'd0, 4'hF);
        read_check("freeze_status", 3'd5, 32'h1);
        wait_neg(2);
        check("freeze_byte1", {24'h0, out_port[15:8]}, {24'h0, BYTE1_VIS});
        wait_neg(10);
        check("freeze_byte1_late", {24'h0, out_port[15:8]}, {24'h0, BYTE1_VIS});
        read_check("freeze_status_late", 3'd5, 32'h1);

        bus_write(3'd4, 32'h03FFFFFF, 4'b0001);
        read_check("period_lane0", 3'd4, 32'h000000FF);
        bus_write(3'd4, 32'hFFFFFFFF, 4'hF);
        read_check("period_width", 3'd4, 32'h03FFFFFF);
        bus_write(3'd6, 32'hFFFFFFFF, 4'hF);
        read_check("unused_addr_write", 3'd0, 32'h44332211);
        read_check("read_addr6", 3'd6, 32'h0);
        read_check("read_set", 3'd1, 32'h0);
        read_check("read_clr", 3'd2, 32'h0);

        bus_write(3'd3, 32'hF, 4'b0010);
        read_check("blink_lane1_ignored", 3'd3, 32'h2);
        bus_write(3'd3, 32'hFF, 4'b0001);
        read_check("blink_masked", 3'd3, 32'hF);

        // Asynchronous reset in the middle of a blinking run.
        bus_write(3'd4, 32'd2, 4'hF);
        wait_neg(5);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("midrst_out_port", out_port, 32'h0);
        check("midrst_status", bus.readdata, 32'h1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        read_check("midrst_data", 3'd0, 32'h0);
        read_check("midrst_period", 3'd4, 32'd25000000);
        read_check("midrst_blink", 3'd3, 32'h0);

        wait_neg(2);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
